// File: rtl/unified_mem_arb_pkg.sv
// Shared types and default widths for the unified instruction/data memory arbiter.
// The optional fetch starvation guard is enabled with UNIFIED_MEM_ARB_STARVE_GUARD_EN.
package unified_mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MEM_LATENCY  = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/unified_mem_arb_pick.sv
// Combinational winner select: data port wins unless the fetch starvation guard fires.
// starve_hit is tied low unless UNIFIED_MEM_ARB_STARVE_GUARD_EN is defined in the top.
module unified_mem_arb_pick
  import unified_mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    dm_req,
  input  logic    starve_hit,
  output logic    valid,
  output req_id_t id
);

  // winner selection
  always_comb begin
    valid = if_req | dm_req;
    if (dm_req && !(if_req && starve_hit)) begin
      id = REQ_DM;
    end else begin
      id = REQ_IF;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port fixed-latency memory shared between fetch (if_*) and data (dm_*) ports.
// Define UNIFIED_MEM_ARB_STARVE_GUARD_EN to let a starved fetch override data priority.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  req_id_t          owner;
  logic             owner_we;
  logic             pick_valid;
  req_id_t          pick_id;
  logic             starve_hit;
  logic             grant;

  unified_mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_hit (starve_hit),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  // RESP doubles as an issue slot so back-to-back accesses need no idle cycle
  assign grant     = (state == IDLE || state == RESP) && pick_valid && !reset;
  assign if_rvalid = (state == RESP) && (owner == REQ_IF) && !reset;
  assign dm_rvalid = (state == RESP) && (owner == REQ_DM) && !reset;
  assign busy      = (state != IDLE);

`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // saturating count of consecutive denied fetch cycles
  always_ff @(posedge clk) begin
    if (reset || !if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));
`else
  // the limit only matters when the guard is built in; this is constant low
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  // memory command and grant decode from the current winner
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      mem_en = 1'b1;
      if (pick_id == REQ_DM) begin
        dm_gnt    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // next-state and latency countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (grant) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // state, owner and response data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= REQ_IF;
      owner_we <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        owner    <= pick_id;
        owner_we <= (pick_id == REQ_DM) && dm_we;
      end
      if (state == WAIT && cnt == '0) begin
        if (owner == REQ_DM) begin
          dm_rdata <= owner_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: a latency-1 arbiter with a small RAM model, plus a latency-3 instance
// checked for back-to-back fetch spacing.
module tb_unified_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = 32'd0, dm_addr = 32'd0, dm_wdata = 32'd0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        f3_req = 1'b0;
  logic [31:0] f3_addr = 32'd0;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] ram [0:255];
  logic        preload = 1'b1;
  logic [31:0] p0, p1, p2;

  mem_cmd_t    exp_mem[$];
  logic [31:0] exp_if[$], exp_dm[$], exp3[$];
  int          if_rv_cyc = 0, dm_rv_cyc = 0, n3 = 0;
  int          r3 [0:2];

  unified_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(f3_req), .if_addr(f3_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM at latency 1: each word preloaded with its address byte repeated, except 0x10
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= {4{i[7:0]}};
      ram[8'h10] <= 32'h0050_0113;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // latency-3 memory returning BEEF in the top half and the address in the bottom half
  always @(posedge clk) begin
    if (mem_en3) p0 <= {16'hBEEF, mem_addr3[15:0]};
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: pops scoreboards whenever the DUTs present a response or command
  always @(negedge clk) begin
    if (if_rvalid) begin
      if_rv_cyc <= cyc;
      if (exp_if.size() == 0) check("if_rvalid_unexpected", 96'd1, 96'd0);
      else check("if_rdata", {64'd0, if_rdata}, {64'd0, exp_if.pop_front()});
    end
    if (dm_rvalid) begin
      dm_rv_cyc <= cyc;
      if (exp_dm.size() == 0) check("dm_rvalid_unexpected", 96'd1, 96'd0);
      else check("dm_rdata", {64'd0, dm_rdata}, {64'd0, exp_dm.pop_front()});
    end
    if (mem_en) begin
      if (exp_mem.size() == 0) check("mem_en_unexpected", 96'd1, 96'd0);
      else check("mem_cmd", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, exp_mem.pop_front()});
    end
    if (if_gnt || dm_gnt) check("single_gnt", {95'd0, if_gnt & dm_gnt}, 96'd0);
    if (if_rvalid3) begin
      if (n3 < 3) r3[n3] <= cyc;
      n3 <= n3 + 1;
      if (exp3.size() == 0) check("l3_rvalid_unexpected", 96'd1, 96'd0);
      else check("l3_rdata", {64'd0, if_rdata3}, {64'd0, exp3.pop_front()});
    end
  end

  task automatic req_if(input logic [31:0] addr, output int g);
    if_req = 1'b1;
    if_addr = addr;
    g = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_gnt) begin g = cyc; break; end
    end
    if (g < 0) check("if_gnt_timeout", 96'd1, 96'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
    if_addr = 32'd0;
  endtask

  task automatic req_dm(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int g);
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = addr;
    dm_wdata = wd;
    g = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dm_gnt) begin g = cyc; break; end
    end
    if (g < 0) check("dm_gnt_timeout", 96'd1, 96'd0);
    @(posedge clk); #1;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = 32'd0;
    dm_wdata = 32'd0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (exp_if.size() == 0 && exp_dm.size() == 0 && exp_mem.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, exp_if.size() + exp_dm.size() + exp_mem.size(), 96'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_ctrl"}, {89'd0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}, 96'd0);
    check({name, "_rdata"}, {32'd0, if_rdata, dm_rdata}, 96'd0);
    check({name, "_mem"}, {32'd0, mem_addr, mem_wdata}, 96'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ga, gb, gc, gd, ge;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    preload = 1'b0;
    check_idle("post_reset");

    // fetch only
    exp_mem.push_back('{1'b0, 32'h10, 32'h0});
    exp_if.push_back(32'h0050_0113);
    req_if(32'h10, ga);
    drain("fetch_drain");
    check("fetch_rv_lat", if_rv_cyc - ga, 96'd2);

    // data write then read back
    exp_mem.push_back('{1'b1, 32'h64, 32'h7});
    exp_dm.push_back(32'h0);
    req_dm(1'b1, 32'h64, 32'h7, ga);
    drain("write_drain");
    check("write_rv_lat", dm_rv_cyc - ga, 96'd2);
    exp_mem.push_back('{1'b0, 32'h64, 32'h0});
    exp_dm.push_back(32'h7);
    req_dm(1'b0, 32'h64, 32'h0, ga);
    drain("readback_drain");

    // simultaneous requests: data first
    exp_mem.push_back('{1'b0, 32'h30, 32'h0});
    exp_mem.push_back('{1'b0, 32'h20, 32'h0});
    exp_dm.push_back(32'h3030_3030);
    exp_if.push_back(32'h2020_2020);
    fork
      req_dm(1'b0, 32'h30, 32'h0, ga);
      req_if(32'h20, gb);
    join
    drain("both_drain");
    check("both_if_gnt", gb - ga, 96'd2);
    check("both_if_rv", if_rv_cyc - ga, 96'd4);

    // continuous data traffic against a waiting fetch
`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    exp_mem.push_back('{1'b0, 32'h44, 32'h0});
    exp_mem.push_back('{1'b0, 32'h50, 32'h0});
    exp_mem.push_back('{1'b0, 32'h48, 32'h0});
`else
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    exp_mem.push_back('{1'b0, 32'h44, 32'h0});
    exp_mem.push_back('{1'b0, 32'h48, 32'h0});
    exp_mem.push_back('{1'b0, 32'h50, 32'h0});
`endif
    exp_dm.push_back(32'h4040_4040);
    exp_dm.push_back(32'h4444_4444);
    exp_dm.push_back(32'h4848_4848);
    exp_if.push_back(32'h5050_5050);
    fork
      begin
        req_dm(1'b0, 32'h40, 32'h0, ga);
        req_dm(1'b0, 32'h44, 32'h0, gc);
        req_dm(1'b0, 32'h48, 32'h0, gd);
      end
      req_if(32'h50, gb);
    join
    drain("starve_drain");
`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
    check("starve_if_gnt", gb - ga, 96'd4);
    check("starve_dm_last", gd - ga, 96'd6);
`else
    check("strict_if_gnt", gb - ga, 96'd6);
    check("strict_dm_last", gd - ga, 96'd4);
`endif

    // reset while waiting on memory: no response, clean outputs, reissue works
    exp_mem.push_back('{1'b0, 32'h24, 32'h0});
    req_if(32'h24, ga);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("mid_reset");
    exp_mem.push_back('{1'b0, 32'h24, 32'h0});
    exp_if.push_back(32'h2424_2424);
    req_if(32'h24, ge);
    drain("reissue_drain");
    check("reissue_rv_lat", if_rv_cyc - ge, 96'd2);

    // latency 3 back-to-back fetches
    begin
      int g3 [0:2];
      exp3.push_back(32'hBEEF_0100);
      exp3.push_back(32'hBEEF_0104);
      exp3.push_back(32'hBEEF_0108);
      f3_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        f3_addr = 32'h100 + 32'(4 * i);
        g3[i] = -1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (if_gnt3) begin g3[i] = cyc; break; end
        end
        check("l3_gnt_seen", {95'd0, g3[i] >= 0}, 96'd1);
        check("l3_mem_addr", {64'd0, mem_addr3}, {64'd0, f3_addr});
        @(posedge clk); #1;
      end
      f3_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (n3 >= 3) break;
        @(posedge clk); #1;
      end
      check("l3_resp_count", n3, 96'd3);
      check("l3_gnt_gap0", g3[1] - g3[0], 96'd4);
      check("l3_gnt_gap1", g3[2] - g3[1], 96'd4);
      for (int i = 0; i < 3; i++) check("l3_rv_lat", r3[i] - g3[i], 96'd4);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
